// File: rtl/seq_tx.sv
// seq_tx: serial MSB-first pattern transmitter with valid/ready word intake and done pulse.
// Optional build macro SEQ_TX_REPEAT_EN adds the rpt port for back-to-back word repetition.
module seq_tx #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic [CNT_W-1:0] len,
   input  logic             valid,
`ifdef SEQ_TX_REPEAT_EN
   input  logic [3:0]       rpt,
`endif
   output logic             ready,
   output logic             Out,
   output logic             active,
   output logic             done
);

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [WIDTH-1:0]   sh_reg, sh_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic               out_reg, out_next;
   logic               active_reg, active_next;
   logic               done_reg, done_next;
   logic               ready_reg, ready_next;
`ifdef SEQ_TX_REPEAT_EN
   logic [WIDTH-1:0]   saved_reg, saved_next;
   logic [CNT_W-1:0]   len_reg, len_next;
   logic [3:0]         rpt_reg, rpt_next;
`endif

   logic [CNT_W-1:0]   l_eff;
   logic [WIDTH-1:0]   aligned;

   // Left-justify the payload so the first bit always sits at the MSB;
   // bits above L-1 fall off the top.
   always_comb begin
      l_eff   = (len == '0 || len > WIDTH_C) ? WIDTH_C : len;
      aligned = data_in << (WIDTH_C - l_eff);
   end

   always_comb begin
      state_next  = state_reg;
      sh_next     = sh_reg;
      cnt_next    = cnt_reg;
      out_next    = 1'b0;
      active_next = 1'b0;
      done_next   = 1'b0;
      ready_next  = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
      saved_next  = saved_reg;
      len_next    = len_reg;
      rpt_next    = rpt_reg;
`endif
      case (state_reg)
         IDLE: begin
            ready_next = 1'b1;
            if (valid && ready_reg) begin
               state_next  = SEND;
               sh_next     = aligned;
               cnt_next    = l_eff;
               out_next    = aligned[WIDTH-1];
               active_next = 1'b1;
               ready_next  = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
               saved_next  = aligned;
               len_next    = l_eff;
               rpt_next    = rpt;
`endif
            end
         end
         SEND: begin
            if (cnt_reg == ONE_C) begin
`ifdef SEQ_TX_REPEAT_EN
               // Reload on the same edge so the stream stays gap-free.
               if (rpt_reg != 4'd0) begin
                  sh_next     = saved_reg;
                  cnt_next    = len_reg;
                  out_next    = saved_reg[WIDTH-1];
                  active_next = 1'b1;
                  rpt_next    = rpt_reg - 4'd1;
               end else begin
                  state_next = GAP;
                  done_next  = 1'b1;
               end
`else
               state_next = GAP;
               done_next  = 1'b1;
`endif
            end else begin
               sh_next     = {sh_reg[WIDTH-2:0], 1'b0};
               cnt_next    = cnt_reg - ONE_C;
               out_next    = sh_reg[WIDTH-2];
               active_next = 1'b1;
            end
         end
         GAP: begin
            state_next = IDLE;
            ready_next = 1'b1;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg  <= IDLE;
         sh_reg     <= '0;
         cnt_reg    <= '0;
         out_reg    <= 1'b0;
         active_reg <= 1'b0;
         done_reg   <= 1'b0;
         ready_reg  <= 1'b0;
`ifdef SEQ_TX_REPEAT_EN
         saved_reg  <= '0;
         len_reg    <= '0;
         rpt_reg    <= 4'd0;
`endif
      end else begin
         state_reg  <= state_next;
         sh_reg     <= sh_next;
         cnt_reg    <= cnt_next;
         out_reg    <= out_next;
         active_reg <= active_next;
         done_reg   <= done_next;
         ready_reg  <= ready_next;
`ifdef SEQ_TX_REPEAT_EN
         saved_reg  <= saved_next;
         len_reg    <= len_next;
         rpt_reg    <= rpt_next;
`endif
      end
   end

   assign ready  = ready_reg;
   assign Out    = out_reg;
   assign active = active_reg;
   assign done   = done_reg;

endmodule

// File: tb/tb_seq_tx.sv
// Directed self-checking bench for seq_tx; define SEQ_TX_REPEAT_EN to also exercise rpt.
module tb_seq_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic [3:0] len = 4'd0;
   logic       valid = 1'b0;
   logic [3:0] rpt = 4'd0;
   logic       ready, Out, active, done;

   int checks = 0;
   int errors = 0;

   seq_tx #(.WIDTH(8)) dut (
      .clock   (clock),
      .reset   (reset),
      .data_in (data_in),
      .len     (len),
      .valid   (valid),
`ifdef SEQ_TX_REPEAT_EN
      .rpt     (rpt),
`endif
      .ready   (ready),
      .Out     (Out),
      .active  (active),
      .done    (done)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cyc(input string tag, input logic o, input logic a,
                          input logic d, input logic r);
      chk({tag, ".Out"}, 32'(Out), 32'(o));
      chk({tag, ".active"}, 32'(active), 32'(a));
      chk({tag, ".done"}, 32'(done), 32'(d));
      chk({tag, ".ready"}, 32'(ready), 32'(r));
   endtask

   // Handshake one word, then check every bit, the done pulse and ready's return.
   task automatic send_word(input string tag, input logic [7:0] d, input logic [3:0] l,
                            input logic [3:0] r, input logic [31:0] exp, input int n);
      data_in = d;
      len     = l;
      rpt     = r;
      valid   = 1'b1;
      tick();
      valid = 1'b0;
      for (int k = 0; k < n; k++) begin
         chk_cyc($sformatf("%s.bit%0d", tag, k), exp[n-1-k], 1'b1, 1'b0, 1'b0);
         tick();
      end
      chk_cyc({tag, ".gap"}, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_cyc({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
      $display("word %s data=%02h len=%0d rpt=%0d bits=%0d", tag, d, l, r, n);
   endtask

   initial begin
      // Reset state; valid high during reset must be ignored
      valid   = 1'b1;
      data_in = 8'hFF;
      tick();
      tick();
      chk_cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      valid = 1'b0;
      reset = 1'b0;
      tick();
      chk_cyc("post_reset", 1'b0, 1'b0, 1'b0, 1'b1);

      send_word("b2_len8", 8'b1011_0010, 4'd8, 4'd0, 32'b1011_0010, 8);
      send_word("a6_len4", 8'hA6, 4'd4, 4'd0, 32'b0110, 4);
      send_word("ff_len0", 8'hFF, 4'd0, 4'd0, 32'hFF, 8);
      send_word("ff_len12", 8'hFF, 4'd12, 4'd0, 32'hFF, 8);
      send_word("len1", 8'h01, 4'd1, 4'd0, 32'b1, 1);

      // valid held high with changing data: only the first word is taken
      data_in = 8'h05;
      len     = 4'd4;
      valid   = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         data_in = (k % 2 == 0) ? 8'hFF : 8'h00;
         chk_cyc($sformatf("hold.bit%0d", k), (k % 2 == 1), 1'b1, 1'b0, 1'b0);
         tick();
      end
      data_in = 8'h03;
      chk_cyc("hold.gap", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_cyc("hold.ready", 1'b0, 1'b0, 1'b0, 1'b1);
      data_in = 8'h0A;
      tick();
      valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk_cyc($sformatf("hold2.bit%0d", k), (k % 2 == 0), 1'b1, 1'b0, 1'b0);
         tick();
      end
      chk_cyc("hold2.gap", 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      chk_cyc("hold2.idle", 1'b0, 1'b0, 1'b0, 1'b1);
      $display("word hold_valid first=05 second=0a");

      // Abort while the 3rd bit is on Out
      data_in = 8'b1011_0010;
      len     = 4'd8;
      valid   = 1'b1;
      tick();
      valid = 1'b0;
      chk_cyc("abort.bit0", 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      chk_cyc("abort.bit1", 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_cyc("abort.bit2", 1'b1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      tick();
      chk_cyc("abort.reset", 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      tick();
      chk_cyc("abort.ready", 1'b0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("abort.nodone%0d", k), 32'(done), 32'd0);
         tick();
      end
      $display("word abort data=b2 len=8 aborted at bit 2");

      send_word("after_abort", 8'h3C, 4'd6, 4'd0, 32'b111100, 6);

`ifdef SEQ_TX_REPEAT_EN
      send_word("rpt2", 8'b101, 4'd3, 4'd2, 32'b101_101_101, 9);
      send_word("rpt1_len2", 8'h02, 4'd2, 4'd1, 32'b1010, 4);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
